// File: rtl/regfile_wb_sched_pkg.sv
// Shared widths, constants and helpers for the regfile write-back scheduler.
// Mirrors the RegAddrBus/RegBus/WriteEnable/ZeroWord definitions used across the core.
package regfile_wb_sched_pkg;

  localparam int REG_ADDR_BUS = 5;
  localparam int REG_BUS      = 32;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [REG_BUS-1:0] ZERO_WORD = '0;

  // Source currently owning the regfile write port.
  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_EX,
    WB_SRC_LU
  } wb_src_e;

  // Width of a counter able to hold 0..max_val (PendCntBus / StarveCntBus).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bits for destinations of in-flight long-latency operations, the
// outstanding-operation count, and the issue hazard (stall) decision.
module reg_scoreboard
  import regfile_wb_sched_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = REG_ADDR_BUS,
  parameter int MAX_PEND = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_re1,
  input  logic [ADDR_W-1:0] issue_raddr1,
  input  logic              issue_re2,
  input  logic [ADDR_W-1:0] issue_raddr2,
  input  logic              issue_wreg,
  input  logic [ADDR_W-1:0] issue_waddr,
  input  logic              issue_long,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic              stall
);

  localparam int PEND_CNT_BUS = cnt_width(MAX_PEND);
  localparam logic [PEND_CNT_BUS-1:0] PEND_FULL = PEND_CNT_BUS'(MAX_PEND);

  logic [NUM_REGS-1:0]     busy_reg;
  logic [NUM_REGS-1:0]     busy_next;
  logic [NUM_REGS-1:0]     eb;
  logic [PEND_CNT_BUS-1:0] pend_cnt_reg;
  logic [PEND_CNT_BUS-1:0] pend_cnt_next;
  logic                    set;
  logic                    hazard;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign eb[gi]        = 1'b0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        // A register being written back this cycle is forwarded by the regfile.
        assign eb[gi] = busy_reg[gi] & ~(clr && (clr_addr == ADDR_W'(gi)));
        assign busy_next[gi] = (set && (issue_waddr == ADDR_W'(gi))) ? 1'b1 :
                               (clr && (clr_addr == ADDR_W'(gi)))    ? 1'b0 :
                               busy_reg[gi];
      end
    end
  endgenerate

  assign hazard = (issue_re1  & eb[issue_raddr1]) |
                  (issue_re2  & eb[issue_raddr2]) |
                  (issue_wreg & eb[issue_waddr])  |
                  (issue_long & (pend_cnt_reg == PEND_FULL));

  assign stall = ~rst & issue_valid & hazard;
  assign set   = issue_valid & issue_wreg & issue_long & ~stall & (issue_waddr != '0);

  always_comb begin
    pend_cnt_next = pend_cnt_reg;
    if (set && !clr) begin
      pend_cnt_next = pend_cnt_reg + 1'b1;
    end else if (clr && !set && (pend_cnt_reg != '0)) begin
      pend_cnt_next = pend_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg     <= '0;
      pend_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Merges pipeline and long-latency write-backs onto the single regfile write
// port, holds the pipeline when a long result starves, and stalls issue on hazards.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = REG_ADDR_BUS,
  parameter int DATA_W     = REG_BUS,
  parameter int MAX_PEND   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_re1,
  input  logic [ADDR_W-1:0] issue_raddr1,
  input  logic              issue_re2,
  input  logic [ADDR_W-1:0] issue_raddr2,
  input  logic              issue_wreg,
  input  logic [ADDR_W-1:0] issue_waddr,
  input  logic              issue_long,
  output logic              stall_o,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              wb_hold,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int STARVE_CNT_BUS = cnt_width(STARVE_MAX);
  localparam logic [STARVE_CNT_BUS-1:0] STARVE_LAST = STARVE_CNT_BUS'(STARVE_MAX - 1);

  wb_src_e                   wb_src;
  logic                      lu_grant;
  logic                      lu_starved;
  logic [STARVE_CNT_BUS-1:0] starve_cnt_reg;
  logic [STARVE_CNT_BUS-1:0] starve_cnt_next;
  logic                      wb_hold_reg;
  logic                      wb_hold_next;

  // The pipeline has no backpressure, so it always wins the port.
  always_comb begin
    wb_src = WB_SRC_NONE;
    if (!rst) begin
      if (ex_we) begin
        wb_src = WB_SRC_EX;
      end else if (lu_valid) begin
        wb_src = WB_SRC_LU;
      end
    end
  end

  assign lu_ready = (wb_src == WB_SRC_LU);
  assign lu_grant = lu_ready;

  always_comb begin
    rf_we    = ~WRITE_ENABLE;
    rf_waddr = '0;
    rf_wdata = DATA_W'(ZERO_WORD);
    case (wb_src)
      WB_SRC_EX: begin
        rf_we    = WRITE_ENABLE;
        rf_waddr = ex_waddr;
        rf_wdata = ex_wdata;
      end
      WB_SRC_LU: begin
        rf_we    = WRITE_ENABLE;
        rf_waddr = lu_waddr;
        rf_wdata = lu_wdata;
      end
      default: ;
    endcase
  end

  assign lu_starved = lu_valid & ~lu_ready;

  // Count saturates at its last value; hold stays up until the long result is granted.
  always_comb begin
    starve_cnt_next = '0;
    wb_hold_next    = 1'b0;
    if (lu_starved) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_LAST) ? starve_cnt_reg
                                                       : starve_cnt_reg + 1'b1;
      wb_hold_next    = wb_hold_reg | (starve_cnt_reg == STARVE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      wb_hold_reg    <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      wb_hold_reg    <= wb_hold_next;
    end
  end

  assign wb_hold = wb_hold_reg;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .MAX_PEND (MAX_PEND)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_re1    (issue_re1),
    .issue_raddr1 (issue_raddr1),
    .issue_re2    (issue_re2),
    .issue_raddr2 (issue_raddr2),
    .issue_wreg   (issue_wreg),
    .issue_waddr  (issue_waddr),
    .issue_long   (issue_long),
    .clr          (lu_grant),
    .clr_addr     (lu_waddr),
    .stall        (stall_o)
  );

endmodule
